// File: rtl/uvma_obi_slv_resp_pipe_pkg.sv
// Shared types and helpers for the OBI slave response pipe.
// Struct fields are sized for the widest supported configuration (64-bit data, 16-bit ids).
package uvma_obi_slv_resp_pipe_pkg;

    localparam int unsigned MAX_ID_W   = 16;
    localparam int unsigned MAX_DATA_W = 64;

    typedef struct packed {
        logic [MAX_ID_W-1:0] aid;
        logic                we;
        logic                local_err;
    } tag_t;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_t;

    // True when the enabled lanes form one non-empty run inside the low nbytes lanes.
    function automatic logic is_contig_be(input logic [7:0] be, input int nbytes);
        logic seen_one;
        logic seen_gap;
        logic ok;
        seen_one = 1'b0;
        seen_gap = 1'b0;
        ok       = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < nbytes) begin
                if (be[3'(i)]) begin
                    if (seen_gap) ok = 1'b0;
                    seen_one = 1'b1;
                end else if (seen_one) begin
                    seen_gap = 1'b1;
                end
            end else if (be[3'(i)]) begin
                ok = 1'b0;
            end
        end
        return ok & seen_one;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] addr_lo, input int nbytes);
        return (nbytes == 8) ? (addr_lo != 3'd0) : (addr_lo[1:0] != 2'd0);
    endfunction

endpackage

// File: rtl/uvma_obi_slv_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty decided by MSB compare.
// Only the pointers are reset; storage contents are don't-care until written.
module uvma_obi_slv_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    assign wptr_d = wptr_q + {{AW{1'b0}}, push_i};
    assign rptr_d = rptr_q + {{AW{1'b0}}, pop_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

    // The outstanding limit upstream makes either of these a design error.
    a_no_overflow:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));

endmodule

// File: rtl/uvma_obi_slv_resp_pipe.sv
// OBI slave shim: forwards A-channel requests to an in-order memory port and returns R responses.
// Optional macro UVMA_OBI_SLV_MISALIGN_ERR_EN answers misaligned/bad-be accesses locally with err=1.
module uvma_obi_slv_resp_pipe
    import uvma_obi_slv_resp_pipe_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              obi_req,
    output logic                              obi_gnt,
    input  logic [ADDR_WIDTH-1:0]             obi_addr,
    input  logic                              obi_we,
    input  logic [DATA_WIDTH/8-1:0]           obi_be,
    input  logic [DATA_WIDTH-1:0]             obi_wdata,
    input  logic [ID_WIDTH-1:0]               obi_aid,
    output logic                              obi_rvalid,
    input  logic                              obi_rready,
    output logic [DATA_WIDTH-1:0]             obi_rdata,
    output logic                              obi_err,
    output logic [ID_WIDTH-1:0]               obi_rid,
    output logic                              mem_req,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic                              mem_we,
    output logic [DATA_WIDTH/8-1:0]           mem_be,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    input  logic                              mem_rvalid,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    input  logic                              mem_err,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding
);

    localparam int unsigned    BEW     = DATA_WIDTH / 8;
    localparam int unsigned    CW      = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0]  ONE     = CW'(1);

    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] mem_pend_q, mem_pend_d;
    logic          accept;
    logic          local_err;
    logic          rsp_hs;
    logic          mem_rsp_keep;
    tag_t          tag_in, tag_head;
    rsp_t          rsp_in, rsp_head;
    logic          tag_full, tag_empty;
    logic          rsp_full, rsp_empty;
    logic          unused_sink;

`ifdef UVMA_OBI_SLV_MISALIGN_ERR_EN
    assign local_err = is_misaligned(obi_addr[2:0], int'(BEW))
                     || !is_contig_be(8'(obi_be), int'(BEW));
`else
    assign local_err = 1'b0;
`endif

    assign obi_gnt   = obi_req && (out_cnt_q < MAX_CNT);
    assign accept    = obi_req && obi_gnt;

    assign mem_req   = accept && !local_err;
    assign mem_addr  = obi_addr;
    assign mem_we    = obi_we;
    assign mem_be    = obi_be;
    assign mem_wdata = obi_wdata;

    assign tag_in.aid       = MAX_ID_W'(obi_aid);
    assign tag_in.we        = obi_we;
    assign tag_in.local_err = local_err;

    // Responses with no access in flight (stale after reset) are discarded.
    assign mem_rsp_keep = mem_rvalid && (mem_pend_q != '0);
    assign rsp_in.rdata = MAX_DATA_W'(mem_rdata);
    assign rsp_in.err   = mem_err;

    uvma_obi_slv_fifo #(
        .WIDTH ($bits(tag_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (accept),
        .data_i  (tag_in),
        .pop_i   (rsp_hs),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .head_o  (tag_head)
    );

    uvma_obi_slv_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (mem_rsp_keep),
        .data_i  (rsp_in),
        .pop_i   (rsp_hs && !tag_head.local_err),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .head_o  (rsp_head)
    );

    assign obi_rvalid = !tag_empty && (tag_head.local_err || !rsp_empty);
    assign rsp_hs     = obi_rvalid && obi_rready;

    // Data entries pair in order with non-local tags, so the head tag's we flag masks write data.
    always_comb begin
        obi_rdata = '0;
        obi_err   = 1'b0;
        obi_rid   = '0;
        if (obi_rvalid) begin
            obi_rid = tag_head.aid[ID_WIDTH-1:0];
            if (tag_head.local_err) begin
                obi_err = 1'b1;
            end else begin
                obi_rdata = tag_head.we ? '0 : rsp_head.rdata[DATA_WIDTH-1:0];
                obi_err   = rsp_head.err;
            end
        end
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({accept, rsp_hs})
            2'b10:   out_cnt_d = out_cnt_q + ONE;
            2'b01:   out_cnt_d = out_cnt_q - ONE;
            default: out_cnt_d = out_cnt_q;
        endcase
        mem_pend_d = mem_pend_q + CW'(mem_req) - CW'(mem_rsp_keep);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_cnt_q  <= '0;
            mem_pend_q <= '0;
        end else begin
            out_cnt_q  <= out_cnt_d;
            mem_pend_q <= mem_pend_d;
        end
    end

    assign outstanding = out_cnt_q;
    assign unused_sink = ^{tag_head, rsp_head, tag_full, rsp_full};

endmodule

// File: tb/tb_uvma_obi_slv_resp_pipe.sv
// Directed bench for uvma_obi_slv_resp_pipe with an in-order response scoreboard and a latency-driven memory.
// Set UVMA_OBI_SLV_MISALIGN_ERR_EN to also exercise the local-error path.
`timescale 1ns/1ps
module tb_uvma_obi_slv_resp_pipe;

    localparam int MO = 4;
`ifdef UVMA_OBI_SLV_MISALIGN_ERR_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        obi_req = 1'b0, obi_gnt;
    logic [31:0] obi_addr = '0;
    logic        obi_we = 1'b0;
    logic [3:0]  obi_be = '0;
    logic [31:0] obi_wdata = '0;
    logic [3:0]  obi_aid = '0;
    logic        obi_rvalid, obi_rready = 1'b1;
    logic [31:0] obi_rdata;
    logic        obi_err;
    logic [3:0]  obi_rid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_err = 1'b0;
    logic [2:0]  outstanding;

    always #5 clk = ~clk;

    uvma_obi_slv_resp_pipe dut (
        .clk(clk), .reset_n(reset_n),
        .obi_req(obi_req), .obi_gnt(obi_gnt), .obi_addr(obi_addr), .obi_we(obi_we),
        .obi_be(obi_be), .obi_wdata(obi_wdata), .obi_aid(obi_aid),
        .obi_rvalid(obi_rvalid), .obi_rready(obi_rready), .obi_rdata(obi_rdata),
        .obi_err(obi_err), .obi_rid(obi_rid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_err(mem_err), .outstanding(outstanding)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bench memory: explicit contents where set, otherwise a fixed address pattern.
    logic [31:0] memarr [logic [31:0]];
    function automatic logic [31:0] memval(input logic [31:0] a);
        return memarr.exists(a) ? memarr[a] : (a ^ 32'h5A5A_0000);
    endfunction
    function automatic logic memerr(input logic [31:0] a);
        return a[31:28] == 4'hE;
    endfunction

    typedef struct { int due; logic [31:0] data; logic err; } mrsp_t;
    mrsp_t rq[$];
    int    cyc = 0;
    int    lat = 2;

    always @(negedge clk) begin
        mrsp_t r;
        if (mem_req) begin
            r.due  = cyc + lat;
            r.data = memval(mem_addr);
            r.err  = memerr(mem_addr);
            rq.push_back(r);
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rq[0].data;
            mem_err    = rq[0].err;
            void'(rq.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            mem_err    = 1'($urandom);
        end
    end

    // Scoreboard: every accepted request owes exactly one in-order response.
    typedef struct { logic [3:0] aid; logic [31:0] rdata; logic err; } exp_t;
    exp_t eq[$];

    function automatic logic bad_access(input logic [31:0] a, input logic [3:0] be);
        logic contig;
        contig = be inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'h7, 4'hE, 4'hF};
        return MISALIGN_EN && ((a[1:0] != 2'b00) || !contig);
    endfunction

    logic        hold_q = 1'b0;
    logic [3:0]  hold_rid;
    logic [31:0] hold_rdata;
    logic        hold_err;

    always @(negedge clk) begin
        logic le;
        exp_t e;
        if (!reset_n) begin
            eq.delete();
            hold_q = 1'b0;
            check("rst_rvalid", obi_rvalid, 1'b0);
            check("rst_outstanding", outstanding, 0);
            check("rst_mem_req", mem_req, 1'b0);
        end else begin
            check("outstanding", outstanding, eq.size());
            check("gnt", obi_gnt, obi_req && (eq.size() < MO));
            check("rvalid_without_pending", obi_rvalid && (eq.size() == 0), 1'b0);
            if (hold_q) begin
                check("hold_rvalid", obi_rvalid, 1'b1);
                check("hold_rid", obi_rid, hold_rid);
                check("hold_rdata", obi_rdata, hold_rdata);
                check("hold_err", obi_err, hold_err);
            end
            if (obi_rvalid && eq.size() > 0) begin
                check("rsp_rid", obi_rid, eq[0].aid);
                check("rsp_rdata", obi_rdata, eq[0].rdata);
                check("rsp_err", obi_err, eq[0].err);
            end
            hold_q     = obi_rvalid && !obi_rready;
            hold_rid   = obi_rid;
            hold_rdata = obi_rdata;
            hold_err   = obi_err;
            if (obi_rvalid && obi_rready && eq.size() > 0) void'(eq.pop_front());
            if (obi_req && obi_gnt) begin
                le = bad_access(obi_addr, obi_be);
                check("fwd_mem_req", mem_req, !le);
                if (!le) begin
                    check("fwd_addr", mem_addr, obi_addr);
                    check("fwd_we", mem_we, obi_we);
                    check("fwd_be", mem_be, obi_be);
                    check("fwd_wdata", mem_wdata, obi_wdata);
                end
                e.aid   = obi_aid;
                e.rdata = (le || obi_we) ? 32'h0 : memval(obi_addr);
                e.err   = le ? 1'b1 : memerr(obi_addr);
                eq.push_back(e);
            end else begin
                check("idle_mem_req", mem_req, 1'b0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        obi_req = 1'b0; obi_we = 1'b0; obi_be = 4'h0; obi_wdata = '0; obi_addr = '0; obi_aid = '0;
    endtask

    task automatic drive_rd(input logic [31:0] a, input logic [3:0] id);
        obi_req = 1'b1; obi_we = 1'b0; obi_be = 4'hF; obi_wdata = '0; obi_addr = a; obi_aid = id;
    endtask

    task automatic wait_rvalid(input int maxc, output int waited, output bit ok);
        ok = 1'b0;
        waited = 0;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (obi_rvalid) begin
                ok = 1'b1;
                waited = k;
                break;
            end
        end
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        obi_rready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (outstanding == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
        step();
    endtask

    initial begin
        int w;
        bit ok;
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        bit ok;
        idle();
        @(negedge clk);
        check("reset_rdata", obi_rdata, 32'h0);
        check("reset_rid", obi_rid, 4'h0);
        check("reset_err", obi_err, 1'b0);
        check("reset_gnt", obi_gnt, 1'b0);
        step(); step();
        reset_n = 1'b1;
        step();

        // Single read, memory latency 2
        memarr[32'h100] = 32'hDEADBEEF;
        lat = 2; obi_rready = 1'b1;
        drive_rd(32'h100, 4'd3);
        @(negedge clk);
        check("t1_gnt", obi_gnt, 1'b1);
        check("t1_mem_req", mem_req, 1'b1);
        step(); idle();
        wait_rvalid(10, w, ok);
        check("t1_rvalid_seen", ok, 1'b1);
        check("t1_latency", w, 3);
        check("t1_rdata", obi_rdata, 32'hDEADBEEF);
        check("t1_rid", obi_rid, 4'd3);
        check("t1_err", obi_err, 1'b0);
        step(); step();

        // Fill to the outstanding limit with rready low
        lat = 1; obi_rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_rd(32'h300 + 32'(4 * i), 4'(i));
            @(negedge clk);
            check("t2_gnt", obi_gnt, (i < 4) ? 1'b1 : 1'b0);
            if (i < 4) step();
        end
        check("t2_outstanding_full", outstanding, 3'd4);
        step(); step();
        obi_rready = 1'b1;
        @(negedge clk);
        check("t2_gnt_in_hs_cycle", obi_gnt, 1'b0);
        check("t2_rvalid_in_hs_cycle", obi_rvalid, 1'b1);
        step();
        obi_rready = 1'b0;
        @(negedge clk);
        check("t2_gnt_after_hs", obi_gnt, 1'b1);
        step(); idle();
        drain("t2_drain");

        // Backpressure with two queued responses
        memarr[32'h200] = 32'h1111_2222;
        memarr[32'h204] = 32'h3333_4444;
        lat = 2; obi_rready = 1'b0;
        drive_rd(32'h200, 4'd1); step();
        drive_rd(32'h204, 4'd2); step();
        idle();
        repeat (4) step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_rvalid", obi_rvalid, 1'b1);
            check("t3_hold_rid", obi_rid, 4'd1);
            check("t3_hold_rdata", obi_rdata, 32'h1111_2222);
            step();
        end
        obi_rready = 1'b1;
        @(negedge clk);
        check("t3_first_rid", obi_rid, 4'd1);
        check("t3_first_rdata", obi_rdata, 32'h1111_2222);
        step();
        @(negedge clk);
        check("t3_second_rvalid", obi_rvalid, 1'b1);
        check("t3_second_rid", obi_rid, 4'd2);
        check("t3_second_rdata", obi_rdata, 32'h3333_4444);
        step();
        drain("t3_drain");

        // Write with memory error
        lat = 2; obi_rready = 1'b1;
        obi_req = 1'b1; obi_we = 1'b1; obi_be = 4'hF; obi_wdata = 32'h1234_5678;
        obi_addr = 32'hE000_0010; obi_aid = 4'd7;
        @(negedge clk);
        check("t4_mem_req", mem_req, 1'b1);
        check("t4_mem_we", mem_we, 1'b1);
        check("t4_mem_wdata", mem_wdata, 32'h1234_5678);
        check("t4_mem_be", mem_be, 4'hF);
        step(); idle();
        wait_rvalid(10, w, ok);
        check("t4_rvalid_seen", ok, 1'b1);
        check("t4_rdata", obi_rdata, 32'h0);
        check("t4_err", obi_err, 1'b1);
        check("t4_rid", obi_rid, 4'd7);
        step(); step();

        // Accept and R handshake in the same cycle
        obi_rready = 1'b0;
        drive_rd(32'h400, 4'd4); step();
        drive_rd(32'h404, 4'd5); step();
        idle();
        wait_rvalid(10, w, ok);
        check("t5_rvalid_seen", ok, 1'b1);
        check("t5_outstanding_before", outstanding, 3'd2);
        step();
        drive_rd(32'h408, 4'd6);
        obi_rready = 1'b1;
        @(negedge clk);
        check("t5_gnt", obi_gnt, 1'b1);
        check("t5_rvalid", obi_rvalid, 1'b1);
        step();
        idle();
        obi_rready = 1'b0;
        @(negedge clk);
        check("t5_outstanding_after", outstanding, 3'd2);
        step();
        drain("t5_drain");

        // Reset with three accesses in flight
        lat = 4; obi_rready = 1'b0;
        drive_rd(32'h500, 4'd8); step();
        drive_rd(32'h504, 4'd9); step();
        drive_rd(32'h508, 4'd10); step();
        idle();
        @(negedge clk);
        check("t6_outstanding_before", outstanding, 3'd3);
        step();
        reset_n = 1'b0;
        #1;
        check("t6_rst_rvalid", obi_rvalid, 1'b0);
        check("t6_rst_outstanding", outstanding, 3'd0);
        check("t6_rst_rdata", obi_rdata, 32'h0);
        check("t6_rst_rid", obi_rid, 4'h0);
        check("t6_rst_err", obi_err, 1'b0);
        check("t6_rst_gnt", obi_gnt, 1'b0);
        check("t6_rst_mem_req", mem_req, 1'b0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t6_no_rvalid", obi_rvalid, 1'b0);
            check("t6_no_outstanding", outstanding, 3'd0);
            step();
        end
        lat = 2; obi_rready = 1'b1;
        drive_rd(32'h600, 4'd11); step();
        idle();
        wait_rvalid(10, w, ok);
        check("t6_new_rvalid_seen", ok, 1'b1);
        check("t6_new_rid", obi_rid, 4'd11);
        check("t6_new_rdata", obi_rdata, 32'h5A5A_0600);
        step(); step();

`ifdef UVMA_OBI_SLV_MISALIGN_ERR_EN
        // Misaligned access answered locally, in order behind a normal read
        lat = 2; obi_rready = 1'b0;
        drive_rd(32'h700, 4'd12); step();
        drive_rd(32'h102, 4'd13);
        @(negedge clk);
        check("t7_gnt", obi_gnt, 1'b1);
        check("t7_mem_req", mem_req, 1'b0);
        step(); idle();
        obi_rready = 1'b1;
        wait_rvalid(10, w, ok);
        check("t7_first_seen", ok, 1'b1);
        check("t7_first_rid", obi_rid, 4'd12);
        check("t7_first_rdata", obi_rdata, 32'h5A5A_0700);
        step();
        @(negedge clk);
        check("t7_err_rvalid", obi_rvalid, 1'b1);
        check("t7_err_rid", obi_rid, 4'd13);
        check("t7_err_err", obi_err, 1'b1);
        check("t7_err_rdata", obi_rdata, 32'h0);
        step();
        drain("t7_drain");
`endif

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
